clock_gate_ctrl: RTL and testbench
==================================

CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent gated-clock channels, range 1..8.
REQ-002 SHALL have parameter WAKE_CYCLES, default 4: settle cycles between clock release and ack, range 1..255.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 3: cycles the clock keeps running after request removal, range 1..255.
REQ-004 SHALL have port clk  input  1  free-running control clock; all state is registered on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_CH  per-channel clock-run request; asynchronous to clk.
REQ-007 SHALL have port force_on  input  1  synchronous global override; all channels run while high.
REQ-008 SHALL have port clk_stop  output  NUM_CH  per-channel stop control, wired directly to a DHCEN CE pin; 1 = clock stopped.
REQ-009 SHALL have port ack  output  NUM_CH  per-channel clock-running-and-settled flag.
REQ-010 SHALL have port busy  output  1  OR of all channels not in OFF.

Function
REQ-011 SHALL pass each req bit through a 2-flop synchronizer; the FSM SHALL see req_s only, 2 edges after req changes.
REQ-012 SHALL implement per channel a registered FSM with states OFF, WAKE, ON, DRAIN and a shared-width 8-bit down counter per channel.
REQ-013 SHALL keep clk_stop and ack as registered outputs decoded from the next state (no combinational path from inputs).
REQ-014 OFF: clk_stop=1, ack=0; on (req_s|force_on)=1 -> WAKE, load counter with WAKE_CYCLES-1, clk_stop=0 on the same edge.
REQ-015 WAKE: clk_stop=0, ack=0; counter decrements each cycle; at counter=0 with request still present -> ON, ack=1 on that edge.
REQ-016 WAKE with request removed before counter=0 -> DRAIN, load DRAIN_CYCLES-1; ack SHALL never pulse.
REQ-017 ON: clk_stop=0, ack=1; on request removal -> DRAIN, ack=0 on the same edge, load counter DRAIN_CYCLES-1.
REQ-018 DRAIN: clk_stop=0, ack=0; counter decrements; at counter=0 with no request -> OFF, clk_stop=1 on that edge.
REQ-019 DRAIN with request re-asserted -> ON on the next edge, ack=1, clock never stopped, counter discarded.
REQ-020 Request here means req_s[i] | force_on; force_on SHALL NOT be synchronized (already in clk domain).
REQ-021 clk_stop[i] SHALL change at most once per clk cycle and only on clk rising edge, so DHCEN sees a glitch-free CE.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each follow REQ-014..019 in the same cycle.
REQ-023 busy SHALL be registered and equal OR over channels of (next state != OFF).
REQ-024 Timing reference: req[i] rising before edge t -> clk_stop[i]=0 after edge t+2, ack[i]=1 after edge t+1+WAKE_CYCLES+1.

Reset
REQ-025 reset high SHALL immediately force all FSMs to OFF, counters to 0, synchronizer flops to 0, clk_stop=all 1, ack=0, busy=0.
REQ-026 reset asserted mid-WAKE, ON or DRAIN SHALL stop the clock at once (clk_stop=1) regardless of counter value.
REQ-027 After reset release, first FSM transition SHALL occur no earlier than 2 edges later (synchronizer refill), even if req held high.

Verification (NUM_CH=2, WAKE_CYCLES=4, DRAIN_CYCLES=3)
REQ-028 req[0] 0->1 before edge 10 -> clk_stop[0]=0 after edge 12, ack[0]=1 after edge 16, channel 1 unchanged (clk_stop[1]=1).
REQ-029 ch0 in ON, req[0] 1->0 before edge 30 -> ack[0]=0 after edge 32, clk_stop[0]=1 after edge 35, busy=0 after edge 35.
REQ-030 ch0 in DRAIN at counter=1, req[0] re-asserted -> ON with ack[0]=1, clk_stop[0] stays 0 throughout (never glitches high).
REQ-031 req[0] pulse 1 cycle wide landing in WAKE -> WAKE->DRAIN->OFF, ack[0] never 1, clk_stop[0] low for exactly WAKE-progress + 3 cycles.
REQ-032 force_on=1 with req=0 -> both channels clk_stop=0 after next edge, ack=1 four edges later; force_on=0 -> both OFF three edges after DRAIN entry.
REQ-033 reset pulsed while both channels ON -> clk_stop=2'b11, ack=2'b00, busy=0 immediately; with req held high, ack returns 2+4 edges after reset release.

Source files
------------

// File: rtl/clock_gate_ctrl.sv
// Per-channel gated-clock controller driving DHCEN stop pins.
// Each channel: 2-flop req sync, OFF/WAKE/ON/DRAIN FSM, registered outputs.
module clock_gate_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int WAKE_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              force_on,
  output logic [NUM_CH-1:0] clk_stop,
  output logic [NUM_CH-1:0] ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [7:0] WAKE_LD  = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CYCLES - 1);

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [7:0]        cnt_q   [NUM_CH];
  logic [7:0]        cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] clk_stop_q, clk_stop_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              busy_q, busy_d;

  // force_on is already in the clk domain, so only req is synchronized
  assign run = sync2_q | {NUM_CH{force_on}};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        OFF: begin
          if (run[i]) begin
            state_d[i] = WAKE;
            cnt_d[i]   = WAKE_LD;
          end
        end
        WAKE: begin
          if (!run[i]) begin
            state_d[i] = DRAIN;
            cnt_d[i]   = DRAIN_LD;
          end else if (cnt_q[i] == 8'd0) begin
            state_d[i] = ON;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        ON: begin
          if (!run[i]) begin
            state_d[i] = DRAIN;
            cnt_d[i]   = DRAIN_LD;
          end
        end
        DRAIN: begin
          if (run[i]) begin
            state_d[i] = ON;
            cnt_d[i]   = 8'd0;
          end else if (cnt_q[i] == 8'd0) begin
            state_d[i] = OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
      endcase
      clk_stop_d[i] = (state_d[i] == OFF);
      ack_d[i]      = (state_d[i] == ON);
    end
    busy_d = ~&clk_stop_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= 8'd0;
      end
      sync1_q    <= '0;
      sync2_q    <= '0;
      clk_stop_q <= '1;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sync1_q    <= req;
      sync2_q    <= sync1_q;
      clk_stop_q <= clk_stop_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  assign clk_stop = clk_stop_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl, NUM_CH=2 WAKE=4 DRAIN=3.
module tb_clock_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic       force_on;
  logic [1:0] clk_stop;
  logic [1:0] ack;
  logic       busy;

  int tests = 0;
  int fails = 0;

  clock_gate_ctrl #(
    .NUM_CH(2),
    .WAKE_CYCLES(4),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .force_on(force_on),
    .clk_stop(clk_stop),
    .ack(ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       frc;
    logic [1:0] stop;
    logic [1:0] ack;
    logic       busy;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [1:0] es,
                     input logic [1:0] ea, input logic eb);
    tests++;
    if (clk_stop !== es || ack !== ea || busy !== eb) begin
      fails++;
      $display("FAIL %s: clk_stop=%b ack=%b busy=%b, want %b %b %b",
               nm, clk_stop, ack, busy, es, ea, eb);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] r, input logic f);
    @(negedge clk);
    req      = r;
    force_on = f;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic f,
                              input logic [1:0] s, input logic [1:0] a,
                              input logic b);
    vec_t v;
    v.req = r; v.frc = f; v.stop = s; v.ack = a; v.busy = b;
    return v;
  endfunction

  initial begin
    int lows;
    int acks;
    // ch0 wake: sync 2 edges, WAKE 4 edges, then ON
    vt[0]  = mk(2'b01, 0, 2'b11, 2'b00, 0);
    vt[1]  = mk(2'b01, 0, 2'b11, 2'b00, 0);
    vt[2]  = mk(2'b01, 0, 2'b10, 2'b00, 1);
    vt[3]  = mk(2'b01, 0, 2'b10, 2'b00, 1);
    vt[4]  = mk(2'b01, 0, 2'b10, 2'b00, 1);
    vt[5]  = mk(2'b01, 0, 2'b10, 2'b00, 1);
    vt[6]  = mk(2'b01, 0, 2'b10, 2'b01, 1);
    vt[7]  = mk(2'b01, 0, 2'b10, 2'b01, 1);
    // ch0 release: DRAIN 2 edges later, OFF 3 edges after that
    vt[8]  = mk(2'b00, 0, 2'b10, 2'b01, 1);
    vt[9]  = mk(2'b00, 0, 2'b10, 2'b01, 1);
    vt[10] = mk(2'b00, 0, 2'b10, 2'b00, 1);
    vt[11] = mk(2'b00, 0, 2'b10, 2'b00, 1);
    vt[12] = mk(2'b00, 0, 2'b10, 2'b00, 1);
    vt[13] = mk(2'b00, 0, 2'b11, 2'b00, 0);
    vt[14] = mk(2'b00, 0, 2'b11, 2'b00, 0);
    // force_on: no sync delay, both channels together
    vt[15] = mk(2'b00, 1, 2'b00, 2'b00, 1);
    vt[16] = mk(2'b00, 1, 2'b00, 2'b00, 1);
    vt[17] = mk(2'b00, 1, 2'b00, 2'b00, 1);
    vt[18] = mk(2'b00, 1, 2'b00, 2'b00, 1);
    vt[19] = mk(2'b00, 1, 2'b00, 2'b11, 1);
    vt[20] = mk(2'b00, 0, 2'b00, 2'b00, 1);
    vt[21] = mk(2'b00, 0, 2'b00, 2'b00, 1);
    vt[22] = mk(2'b00, 0, 2'b00, 2'b00, 1);
    vt[23] = mk(2'b00, 0, 2'b11, 2'b00, 0);

    req      = 2'b00;
    force_on = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_state", 2'b11, 2'b00, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc(vt[i].req, vt[i].frc);
      chk($sformatf("vec%0d", i), vt[i].stop, vt[i].ack, vt[i].busy);
    end

    // re-request while DRAIN counter is at 1
    for (int i = 0; i < 7; i++) cyc(2'b01, 0);
    chk("rearm_on", 2'b10, 2'b01, 1);
    cyc(2'b00, 0); chk("rearm_t0", 2'b10, 2'b01, 1);
    cyc(2'b00, 0); chk("rearm_t1", 2'b10, 2'b01, 1);
    cyc(2'b01, 0); chk("rearm_drn2", 2'b10, 2'b00, 1);
    cyc(2'b01, 0); chk("rearm_drn1", 2'b10, 2'b00, 1);
    cyc(2'b01, 0); chk("rearm_back_on", 2'b10, 2'b01, 1);
    for (int i = 0; i < 6; i++) cyc(2'b00, 0);
    chk("rearm_off", 2'b11, 2'b00, 0);

    // one-cycle req pulse: WAKE once, then DRAIN, no ack
    lows = 0;
    acks = 0;
    cyc(2'b01, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(2'b00, 0);
      if (!clk_stop[0]) lows++;
      if (ack[0]) acks++;
    end
    chk_int("pulse_stop_low", lows, 4);
    chk_int("pulse_ack", acks, 0);
    chk("pulse_end", 2'b11, 2'b00, 0);

    // async reset while both ON
    for (int i = 0; i < 8; i++) cyc(2'b11, 0);
    chk("both_on", 2'b00, 2'b11, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", 2'b11, 2'b00, 0);
    @(posedge clk);
    #1;
    chk("rst_held", 2'b11, 2'b00, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_rel_e%0d", k),
          (k >= 3) ? 2'b00 : 2'b11,
          (k >= 7) ? 2'b11 : 2'b00,
          (k >= 3) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
